// File: rtl/kms_pkg.sv
// Shared definitions for the KMS event scheduler: event types, dispatcher
// states and the saturating arithmetic used by the accumulators and counters.
package kms_pkg;

  localparam logic [1:0] KMS_MOUSE_X = 2'd0;
  localparam logic [1:0] KMS_MOUSE_Y = 2'd1;
  localparam logic [1:0] KMS_KEY     = 2'd2;
  localparam logic [1:0] KMS_OSD     = 2'd3;

  localparam int KMS_EVT_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_KBD_WAIT,
    ST_OSD_WAIT
  } sched_state_t;

  // Signed 8-bit add clamped to -128..+127.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {a[7], a} + {b[7], b};
    if (sum[8] != sum[7]) sat_add8 = sum[8] ? 8'h80 : 8'h7F;
    else                  sat_add8 = sum[7:0];
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] a, input logic [1:0] n);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'd0, n};
    sat_inc8 = sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/kms_fifo.sv
// Synchronous FIFO for captured KMS events. A push while full is accepted
// only when a pop frees a slot in the same cycle.
module kms_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en    = pop && !empty;
  assign wr_en    = push && (!full || rd_en);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/kms_scheduler.sv
// Turns toggle-coded KMS events from the SPI user-I/O block into mouse
// accumulator updates and keyboard/OSD handshakes, strictly in arrival order.
module kms_scheduler
  import kms_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int ACK_TIMEOUT = 65535,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       kms_level,
  input  logic [1:0] kms_type,
  input  logic [7:0] kms_data,
  input  logic       mouse_rd,
  output logic [7:0] mouse_dx,
  output logic [7:0] mouse_dy,
  output logic       kbd_valid,
  output logic [7:0] kbd_code,
  input  logic       kbd_ack,
  output logic       osd_valid,
  output logic [7:0] osd_code,
  input  logic       osd_ack,
  output logic       overflow,
  output logic [7:0] drop_cnt
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   level_prev;
  logic                   base_ok;
  logic                   level_evt;
  logic [KMS_EVT_W-1:0]   head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
  logic                   full_drop;
  logic                   timeout_drop;
  logic [1:0]             drop_inc;
  logic [TW-1:0]          timer;
  logic [7:0]             dx_base;
  logic [7:0]             dy_base;
  sched_state_t           state;
  sched_state_t           state_next;

  // fill_q marks when the chain holds real samples; that first level is the
  // baseline, so a level already high out of reset never becomes an event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      fill_q     <= '0;
      level_prev <= 1'b0;
      base_ok    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], kms_level};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      if (fill_q[SYNC_STAGES-1]) begin
        level_prev <= sync_q[SYNC_STAGES-1];
        base_ok    <= 1'b1;
      end
    end
  end

  assign level_evt = base_ok && (sync_q[SYNC_STAGES-1] != level_prev);
  assign pop       = (state == ST_DISPATCH);
  assign full_drop = level_evt && fifo_full && !pop;

  kms_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KMS_EVT_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (level_evt),
    .push_data ({kms_type, kms_data}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next   = state;
    timeout_drop = 1'b0;
    case (state)
      ST_IDLE:     if (!fifo_empty) state_next = ST_DISPATCH;
      ST_DISPATCH: begin
        case (head[9:8])
          KMS_KEY: state_next = ST_KBD_WAIT;
          KMS_OSD: state_next = ST_OSD_WAIT;
          default: state_next = ST_IDLE;
        endcase
      end
      ST_KBD_WAIT: begin
        if (kbd_ack) begin
          state_next = ST_IDLE;
        end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
          state_next   = ST_IDLE;
          timeout_drop = 1'b1;
        end
      end
      ST_OSD_WAIT: begin
        if (osd_ack) begin
          state_next = ST_IDLE;
        end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
          state_next   = ST_IDLE;
          timeout_drop = 1'b1;
        end
      end
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 timer <= '0;
    else if (state == ST_DISPATCH) timer <= '0;
    else if (state == ST_KBD_WAIT || state == ST_OSD_WAIT) timer <= timer + TW'(1);
  end

  assign kbd_valid = (state == ST_KBD_WAIT);
  assign osd_valid = (state == ST_OSD_WAIT);

  // A read clears to zero first, so a mouse event in the same cycle lands on a clean accumulator.
  assign dx_base  = mouse_rd ? 8'h00 : mouse_dx;
  assign dy_base  = mouse_rd ? 8'h00 : mouse_dy;
  assign drop_inc = {1'b0, full_drop} + {1'b0, timeout_drop};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mouse_dx <= 8'h00;
      mouse_dy <= 8'h00;
      kbd_code <= 8'h00;
      osd_code <= 8'h00;
      overflow <= 1'b0;
      drop_cnt <= 8'h00;
    end else begin
      mouse_dx <= (pop && head[9:8] == KMS_MOUSE_X) ? sat_add8(dx_base, head[7:0]) : dx_base;
      mouse_dy <= (pop && head[9:8] == KMS_MOUSE_Y) ? sat_add8(dy_base, head[7:0]) : dy_base;
      if (pop && head[9:8] == KMS_KEY) kbd_code <= head[7:0];
      if (pop && head[9:8] == KMS_OSD) osd_code <= head[7:0];
      if (full_drop)                   overflow <= 1'b1;
      if (drop_inc != 2'd0)            drop_cnt <= sat_inc8(drop_cnt, drop_inc);
    end
  end

endmodule

// File: doc/kms_scheduler.md
KMS_SCHEDULER -- requirements
Module: kms_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, event FIFO entries; power of two, 4..32.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 65535, clk cycles to wait for a consumer ack before dropping an event.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth on kms_level.
REQ-004 clk  in  1  single core clock; all state on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 kms_level  in  1  event toggle from the SPI user-I/O block, asynchronous to clk.
REQ-007 kms_type  in  2  0=mouse X, 1=mouse Y, 2=keycode, 3=OSD key; stable when kms_level toggles.
REQ-008 kms_data  in  8  event payload; stable when kms_level toggles.
REQ-009 mouse_rd  in  1  one-cycle pulse from the mouse counter logic; read-and-clear of the accumulators.
REQ-010 mouse_dx, mouse_dy  out  8 each  signed accumulated movement.
REQ-011 kbd_valid  out  1, kbd_code  out  8, kbd_ack  in  1  keyboard-serialiser handshake.
REQ-012 osd_valid  out  1, osd_code  out  8, osd_ack  in  1  OSD-controller handshake.
REQ-013 overflow  out  1  sticky: an event was dropped because the FIFO was full.
REQ-014 drop_cnt  out  8  count of dropped events (FIFO full or ack timeout).

Function
REQ-015 SHALL synchronise kms_level through SYNC_STAGES flops; each edge of the synchronised signal is one event.
REQ-016 SHALL capture {kms_type,kms_data} on the same cycle the synchronised edge is detected.
REQ-017 SHALL push each event into a FIFO_DEPTH x 10 FIFO, in order.
REQ-018 On push while full: drop the event, set overflow, saturating-increment drop_cnt; FIFO contents unchanged.
REQ-019 Push and pop in the same cycle while full: the pop frees the slot, so the push is accepted.
REQ-020 Dispatcher FSM states: IDLE, DISPATCH, KBD_WAIT, OSD_WAIT.
REQ-021 IDLE -> DISPATCH when the FIFO is non-empty.
REQ-022 DISPATCH pops the head and routes it by type:
  - mouse (type 0 or 1): accumulate, then return to IDLE;
  - type 2: go to KBD_WAIT;
  - type 3: go to OSD_WAIT.
REQ-023 Mouse accumulation SHALL be signed 8-bit add with saturation to -128..+127; type 0 updates mouse_dx, type 1 updates mouse_dy.
REQ-024 Ordering SHALL be strict: no later event is dispatched while in KBD_WAIT or OSD_WAIT.
REQ-025 KBD_WAIT: kbd_valid=1 and kbd_code held stable.
  - kbd_ack sampled high: clear kbd_valid, go to IDLE.
  - ACK_TIMEOUT cycles without ack: clear kbd_valid, saturating-increment drop_cnt, go to IDLE.
REQ-026 OSD_WAIT behaves identically using osd_valid, osd_code and osd_ack.
REQ-027 An ack arriving while the matching valid is low SHALL be ignored.
REQ-028 mouse_rd SHALL clear both accumulators.
  - mouse_dx/dy show the pre-clear values during the mouse_rd cycle.
  - A mouse event accumulated in the same cycle becomes the new accumulator value (no loss).
REQ-029 Latency: mouse events reach mouse_dx/dy 2 cycles after the FIFO becomes non-empty; kbd_valid/osd_valid rise 2 cycles after non-empty.
REQ-030 overflow SHALL clear only on reset.

Reset
REQ-031 reset_n low SHALL asynchronously clear:
  - FIFO pointers and synchroniser;
  - FSM state to IDLE and the timeout counter;
  - mouse_dx, mouse_dy, kbd_code, osd_code to 0;
  - kbd_valid, osd_valid, overflow to 0;
  - drop_cnt to 0.
REQ-032 Reset asserted during KBD_WAIT or OSD_WAIT SHALL drop the pending event and deassert valid immediately.
REQ-033 The first synchronised level after reset SHALL be taken as the baseline; no spurious event is generated.

Structure
REQ-034 Shared package kms_pkg SHALL hold the event-type constants (KMS_MOUSE_X, KMS_MOUSE_Y, KMS_KEY, KMS_OSD) and the FSM state encoding.
REQ-035 The FIFO SHALL be a separate sub-module kms_fifo (sync FIFO with full/empty outputs and reset_n); the dispatcher and accumulators live in kms_scheduler.

Verification
REQ-036 Toggle kms_level with type 0/data 0x05, then type 1/data 0xFD -> mouse_dx=0x05, mouse_dy=0xFD; mouse_rd pulse -> both 0 on the next cycle.
REQ-037 Three type-0 events of +100 -> mouse_dx saturates at 0x7F; three of -100 after a clear -> 0x80.
REQ-038 Type-2 code 0x45 followed by type-0 +1, kbd_ack held low for 10 cycles -> mouse_dx stays 0 until kbd_ack, then becomes 1 two cycles after the ack.
REQ-039 FIFO_DEPTH+2 events injected while kbd_ack is held low -> overflow=1, drop_cnt=1 (the first event is already dispatched, so one is dropped); remaining events drain in order after acks.
REQ-040 ACK_TIMEOUT=16, OSD event with osd_ack never asserted -> osd_valid drops after 16 cycles, drop_cnt increments by 1, the next event is dispatched.
REQ-041 reset_n pulsed low during KBD_WAIT -> kbd_valid=0 immediately; after release, FIFO empty and no event generated from the existing kms_level.
